// File: rtl/dsc_mul_n_if.sv
// Handshake and operand/result bus for the DSC N-input multiplier.
interface dsc_mul_n_if #(
    parameter int unsigned DW = 32
);
    logic          start;
    logic          op;
    logic [DW-1:0] bin_in;
    logic [DW-1:0] z;
    logic          busy;
    logic          done;

    // Requester drives operands and start; it observes the result and status.
    modport master (
        output start,
        output op,
        output bin_in,
        input  z,
        input  busy,
        input  done
    );

    // The multiplier consumes operands and start; it drives the result and status.
    modport slave (
        input  start,
        input  op,
        input  bin_in,
        output z,
        output busy,
        output done
    );
endinterface

// File: rtl/dsc_mul_n.sv
// Deterministic stochastic-computing N-input multiplier / OR-combiner.
// Each channel compares a free-running counter against its latched operand.
// Counters are clock-enable chained, so every counter tuple occurs exactly once
// over 2^(N*W) cycles. The ones of the combined stream are counted, which gives
// an exact binary product (AND) or its complementary union (OR).
module dsc_mul_n #(
    parameter int unsigned SNG_WIDTH  = 8,
    parameter int unsigned NUM_INPUTS = 4
) (
    input  logic        clk,
    input  logic        rst,
    dsc_mul_n_if.slave  bus
);
    localparam int unsigned W  = SNG_WIDTH;
    localparam int unsigned N  = NUM_INPUTS;
    localparam int unsigned AW = N * W;
    localparam logic [W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N-1:0][W-1:0]  cnt_q, cnt_d;
    logic [N-1:0][W-1:0]  x_q, x_d;
    logic                 op_q, op_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        z_q, z_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [N-1:0]         s_c;
    logic [N-1:0]         en_c;
    logic                 all_max_c;
    logic                 m_c;
    logic [AW-1:0]        acc_sum_c;

    // Unary streams, enable chain, and the accumulator value after this cycle.
    always_comb begin
        s_c       = '0;
        en_c      = '0;
        all_max_c = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            s_c[i] = (cnt_q[i] < x_q[i]);
            if (cnt_q[i] != CNT_MAX) begin
                all_max_c = 1'b0;
            end
        end
        en_c[0] = 1'b1;
        for (int i = 1; i < int'(N); i++) begin
            en_c[i] = en_c[i-1] & (cnt_q[i-1] == CNT_MAX);
        end
        m_c       = op_q ? (|s_c) : (&s_c);
        acc_sum_c = acc_q + AW'(m_c);
    end

    // Next-state and next-output logic for IDLE -> RUN -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        op_d    = op_q;
        acc_d   = acc_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.bin_in;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum_c;
                for (int i = 0; i < int'(N); i++) begin
                    if (en_c[i]) begin
                        cnt_d[i] = cnt_q[i] + W'(1);
                    end
                end
                // The all-max tuple is the last of the sequence; its contribution is included.
                if (all_max_c) begin
                    z_d     = acc_sum_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            op_q    <= 1'b0;
            acc_q   <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.z    = z_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_dsc_mul_n.sv
// Directed self-checking bench for dsc_mul_n in two configurations:
// A: N=2, W=3 (L=64) and B: N=4, W=2 (L=256).
module tb_dsc_mul_n;
    localparam int LA = 64;
    localparam int LB = 256;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    dsc_mul_n_if #(.DW(6)) ia ();
    dsc_mul_n_if #(.DW(8)) ib ();

    dsc_mul_n #(.SNG_WIDTH(3), .NUM_INPUTS(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia.slave)
    );

    dsc_mul_n #(.SNG_WIDTH(2), .NUM_INPUTS(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib.slave)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] last_a = '0;
    logic [63:0] last_b = '0;

    // Closed-form result: product of operands, or L minus product of complements.
    function automatic logic [63:0] model(input int n, input int w, input logic o,
                                          input int x0, input int x1, input int x2, input int x3);
        int          xs[4];
        logic [63:0] prod;
        logic [63:0] full;
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        full  = 64'(1) << (n * w);
        prod  = 64'(1);
        for (int i = 0; i < n; i++) begin
            if (o) prod = prod * 64'((1 << w) - xs[i]);
            else   prod = prod * 64'(xs[i]);
        end
        return o ? (full - prod) : prod;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a start request on A and push its expected result.
    task automatic start_a(input logic o, input int a, input int b);
        ia.start  = 1'b1;
        ia.op     = o;
        ia.bin_in = {3'(b), 3'(a)};
        q_a.push_back(model(2, 3, o, a, b, 0, 0));
    endtask

    task automatic start_b(input logic o, input int x0, input int x1, input int x2, input int x3);
        ib.start  = 1'b1;
        ib.op     = o;
        ib.bin_in = {2'(x3), 2'(x2), 2'(x1), 2'(x0)};
        q_b.push_back(model(4, 2, o, x0, x1, x2, x3));
    endtask

    // Wait for done on A; optionally inject ignored inputs mid-run or reset mid-run.
    task automatic wait_a(input string tag, input bit drop_start, input int inject_at, input int rst_at);
        int          n       = 0;
        int          busy_n  = 0;
        bit          seen    = 1'b0;
        bit          z_moved = 1'b0;
        logic [63:0] exp;
        while (!seen && n < LA + 20) begin
            @(negedge clk);
            n++;
            if (inject_at > 0 && n == inject_at) begin
                ia.start  = 1'b1;
                ia.op     = ~ia.op;
                ia.bin_in = 6'b111_111;
            end else if (drop_start && !(inject_at > 0 && n > inject_at && n < inject_at + 3)) begin
                ia.start = 1'b0;
            end
            if (rst_at > 0 && n == rst_at) begin
                rst_a = 1'b1;
                @(negedge clk);
                check({tag, "_rst_busy"}, 64'(ia.busy), 64'(0));
                check({tag, "_rst_done"}, 64'(ia.done), 64'(0));
                check({tag, "_rst_z"},    64'(ia.z),    64'(0));
                rst_a = 1'b0;
                q_a.delete();
                last_a = '0;
                return;
            end
            if (ia.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (ia.busy === 1'b1) busy_n++;
                if (64'(ia.z) !== last_a) z_moved = 1'b1;
            end
        end
        check({tag, "_lat"},    64'(n),       64'(LA + 1));
        check({tag, "_busy_n"}, 64'(busy_n),  64'(LA));
        check({tag, "_z_hold"}, 64'(z_moved), 64'(0));
        exp = (q_a.size() > 0) ? q_a.pop_front() : 64'hDEAD_BEEF;
        check({tag, "_z"}, 64'(ia.z), exp);
        last_a = exp;
        @(negedge clk);
        if (drop_start) ia.start = 1'b0;
        check({tag, "_pulse_done"}, 64'(ia.done), 64'(0));
        check({tag, "_pulse_busy"}, 64'(ia.busy), 64'(0));
    endtask

    task automatic wait_b(input string tag);
        int          n      = 0;
        int          busy_n = 0;
        bit          seen   = 1'b0;
        logic [63:0] exp;
        while (!seen && n < LB + 20) begin
            @(negedge clk);
            n++;
            ib.start = 1'b0;
            if (ib.done === 1'b1) seen = 1'b1;
            else if (ib.busy === 1'b1) busy_n++;
        end
        check({tag, "_lat"},    64'(n),      64'(LB + 1));
        check({tag, "_busy_n"}, 64'(busy_n), 64'(LB));
        exp = (q_b.size() > 0) ? q_b.pop_front() : 64'hDEAD_BEEF;
        check({tag, "_z"}, 64'(ib.z), exp);
        last_b = exp;
        @(negedge clk);
        check({tag, "_pulse_done"}, 64'(ib.done), 64'(0));
    endtask

    task automatic run_a(input string tag, input logic o, input int a, input int b, input int inject_at);
        start_a(o, a, b);
        wait_a(tag, 1'b1, inject_at, 0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ia.start = 1'b0; ia.op = 1'b0; ia.bin_in = '0;
        ib.start = 1'b0; ib.op = 1'b0; ib.bin_in = '0;
        repeat (2) @(negedge clk);
        check("a_reset_z",    64'(ia.z),    64'(0));
        check("a_reset_busy", 64'(ia.busy), 64'(0));
        check("a_reset_done", 64'(ia.done), 64'(0));
        check("b_reset_z",    64'(ib.z),    64'(0));
        check("b_reset_busy", 64'(ib.busy), 64'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Basic products and unions on A.
        run_a("and_3_5", 1'b0, 3, 5, 0);
        run_a("or_3_5",  1'b1, 3, 5, 0);
        run_a("and_7_7", 1'b0, 7, 7, 0);
        run_a("or_7_7",  1'b1, 7, 7, 0);
        run_a("and_0_6", 1'b0, 0, 6, 0);
        run_a("or_0_0",  1'b1, 0, 0, 0);

        // start plus changed operands/op mid-run must be ignored.
        run_a("inject", 1'b0, 3, 5, 10);

        // Synchronous reset at cycle 20 of a run, then a fresh run.
        start_a(1'b0, 3, 5);
        wait_a("midrst", 1'b1, 0, 20);
        @(negedge clk);
        run_a("after_rst", 1'b0, 3, 5, 0);

        // start held high: one operation every L+2 cycles with fresh operands.
        start_a(1'b0, 3, 5);
        wait_a("held0", 1'b0, 0, 0);
        ia.op = 1'b1; ia.bin_in = {3'(6), 3'(2)};
        q_a.push_back(model(2, 3, 1'b1, 2, 6, 0, 0));
        wait_a("held1", 1'b0, 0, 0);
        ia.op = 1'b0; ia.bin_in = {3'(6), 3'(4)};
        q_a.push_back(model(2, 3, 1'b0, 4, 6, 0, 0));
        wait_a("held2", 1'b1, 0, 0);
        ia.start = 1'b0;

        // Four-channel configuration.
        start_b(1'b0, 1, 2, 3, 3);
        wait_b("b_and_1233");
        start_b(1'b1, 3, 3, 3, 3);
        wait_b("b_or_max");
        start_b(1'b0, 3, 0, 2, 1);
        wait_b("b_and_zero");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dsc_mul_n.md
Name: dsc_mul_n

Overview:
- Parametrised deterministic stochastic-computing (DSC) N-input multiplier / OR-combiner.
- Successor to the fixed 4-input, 8-bit serial multiplier.
- NUM_INPUTS unary stream generators are built from clock-enable-chained counters on a single clock, with no ripple clocks. The block counts ones of the combined stream over exactly 2^(NUM_INPUTS*SNG_WIDTH) cycles and produces an exact binary result.
- Adds a start/busy/done handshake, operand latching and a selectable AND/OR combine mode.

Parameters:
- SNG_WIDTH, 8, bit width of each operand and its stream counter.
- NUM_INPUTS, 4, number of operands/channels (>=2).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- op  input  1  combine mode, latched with start: 0 = AND (product), 1 = OR.
- bin_in  input  NUM_INPUTS*SNG_WIDTH  packed operands; channel i = bin_in[i*SNG_WIDTH +: SNG_WIDTH], channel 0 in the LSBs.
- z  output  NUM_INPUTS*SNG_WIDTH  registered result of the last completed operation.
- busy  output  1  high while an operation is running.
- done  output  1  one-cycle pulse when z is updated.

Behaviour:
- Reset (synchronous, at any time including mid-run):
  - state=IDLE; z=0, busy=0, done=0.
  - All channel counters and the accumulator are 0; latched operands and op are 0.
- Definitions:
  - W=SNG_WIDTH, N=NUM_INPUTS, L=2^(N*W).
- States:
  - IDLE: on start=1 at edge E0, latch bin_in and op; clear counters cnt_0..cnt_{N-1} and accumulator; go to RUN, so busy=1 from E0. start=0 stays in IDLE.
  - RUN: lasts exactly L cycles (edges E1..EL). start is ignored, and bin_in/op changes have no effect.
  - DONE: occupies the single cycle after EL: done=1, busy=0. Returns to IDLE at the next edge. start in the DONE cycle is ignored.
- Stream generation (each RUN cycle, from current counter values):
  - s_i = (cnt_i < x_i), where x_i is the latched operand i, unsigned compare.
  - cnt_0 increments every RUN cycle.
  - cnt_i (i>0) increments only when cnt_0..cnt_{i-1} are all at 2^W-1 (clock-enable chaining, same clk).
  - All counters wrap to 0. Over L cycles every counter tuple occurs exactly once.
- Combine and accumulate:
  - op=0: m = AND of all s_i. op=1: m = OR of all s_i.
  - Accumulator (N*W bits) += m at each RUN edge.
  - The final count is exact: op=0 gives prod(x_i); op=1 gives L - prod(2^W - x_i).
  - Both are <= L-1, so no overflow. The accumulator is not saturating, and overflow is unreachable by construction.
- Completion:
  - At EL (the edge on which all counters are at 2^W-1 and wrap), z <= final accumulator value (including the cycle-L contribution), done <= 1, busy <= 0.
  - z holds its value until the next completion or reset. z does not change during RUN; the previous result stays visible.
- Latency: done is high in the cycle after edge E(L). Start-to-done = L+1 cycles; back-to-back throughput is one operation per L+2 cycles.
- Boundary cases:
  - Any x_i=0 with op=0 gives z=0.
  - All x_i=0 with op=1 gives z=0.
  - All x_i=2^W-1 with op=1 gives z=L-1.
  - start held high continuously starts a new operation in every IDLE cycle reached, i.e. one op every L+2 cycles.

Test Plan:
- N=2, W=3 (L=64), op=0, a=3, b=5, start pulse -> busy for 64 cycles; done pulses exactly once, 65 cycles after start edge; z=15.
- Same params, op=1, a=3, b=5 -> z=64-5*3=49. Then op=0, a=7, b=7 -> z=49. Then op=1, a=7, b=7 -> z=63. Then op=0, a=0, b=6 -> z=0.
- N=4, W=2 (L=256), op=0, operands 1, 2, 3, 3 -> z=18, done 257 cycles after start.
- N=2, W=3: start and changed bin_in/op asserted mid-RUN -> ignored; result unchanged (z=15 for 3, 5, AND). z keeps its old value until done.
- Assert rst at cycle 20 of a run -> next cycle busy=0, done=0, z=0. A fresh start then completes normally with the correct z.
- start held high, N=2, W=3 -> done pulses every 66 cycles; z is correct each time for the bin_in value sampled at each start.
